// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the KxK convolution MAC engine:
//   - state_t    : engine FSM encoding (IDLE=0, RUN=1)
//   - clog2      : ceiling log2 helper usable in constant expressions
//   - conv_acc_w : accumulator width, 2*DATA_W + clog2(K*K)
//   - CONV_TAP   : macro that slices tap t out of a flat DATA_W-packed bus
// ---------------------------------------------------------------------------
`ifndef CONV_PKG_SV
`define CONV_PKG_SV

`define CONV_TAP(flat, t, w) flat[(t)*(w) +: (w)]

package conv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Sum of K*K full-width products never exceeds this width.
    function automatic int conv_acc_w(input int data_w, input int k);
        return 2 * data_w + clog2(k * k);
    endfunction

endpackage

`endif

// File: rtl/conv_mac_lane.sv
// ---------------------------------------------------------------------------
// conv_mac_lane
// One DATA_W x DATA_W multiplier whose 2*DATA_W product is extended to ACC_W
// (sign-extended when SIGNED != 0, zero-extended otherwise).
// Ports:
//   a, b  in   DATA_W  operands
//   p     out  ACC_W   extended product
// ---------------------------------------------------------------------------
module conv_mac_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  p
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int EXT_W  = ACC_W - PROD_W;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;

    // Extending both operands to the product width first makes the low
    // PROD_W bits of an unsigned multiply equal the two's-complement product.
    generate
        if (SIGNED != 0) begin : g_signed
            assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
            assign b_ext = {{DATA_W{b[DATA_W-1]}}, b};
            assign prod  = a_ext * b_ext;
            assign p     = {{EXT_W{prod[PROD_W-1]}}, prod};
        end else begin : g_unsigned
            assign a_ext = {{DATA_W{1'b0}}, a};
            assign b_ext = {{DATA_W{1'b0}}, b};
            assign prod  = a_ext * b_ext;
            assign p     = {{EXT_W{1'b0}}, prod};
        end
    endgenerate

endmodule

// File: rtl/conv_kxk_mac_engine.sv
// ---------------------------------------------------------------------------
// conv_kxk_mac_engine
// Time-multiplexed KxK 2-D convolution (MODE=0, kernel flipped in both axes)
// or correlation (MODE=1). LANES products are accumulated per cycle, so an
// operation takes N = ceil(K*K/LANES) cycles from accept to result.
//
// Optional feature macro: CONV_BIAS_EN (adds the bias port, which seeds the
// accumulator at the accept edge).
//
// Handshake: start is sampled only in IDLE; the accept edge captures x_flat,
// k_flat (and bias). busy is high from the accept edge to the result edge,
// done pulses for one cycle after the result edge, and result holds until
// the next result edge. start high during the done cycle is accepted.
//
// Ports:
//   clk      in   1            rising-edge clock
//   reset_n  in   1            asynchronous active-low reset
//   start    in   1            operation request
//   x_flat   in   K*K*DATA_W   window, x[i][j] at tap i*K+j
//   k_flat   in   K*K*DATA_W   kernel, same packing
//   bias     in   ACC_W        accumulator seed (CONV_BIAS_EN only)
//   busy     out  1            operation in progress
//   done     out  1            one-cycle result-valid pulse
//   result   out  ACC_W        last completed sum
// ---------------------------------------------------------------------------
module conv_kxk_mac_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int LANES  = 1,
    parameter int SIGNED = 0,
    parameter int MODE   = 0,
    localparam int ACC_W = conv_acc_w(DATA_W, K)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [K*K*DATA_W-1:0]   x_flat,
    input  logic [K*K*DATA_W-1:0]   k_flat,
`ifdef CONV_BIAS_EN
    input  logic [ACC_W-1:0]        bias,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        result
);
    localparam int TAPS  = K * K;
    // tap + lane index stays below 2*TAPS; one spare bit keeps the
    // flip subtraction from aliasing.
    localparam int TAP_W = clog2(2 * TAPS) + 1;
    localparam int SEL_W = clog2(TAPS);
    localparam logic [TAP_W-1:0] TAPS_V  = TAP_W'(TAPS);
    localparam logic [TAP_W-1:0] LANES_V = TAP_W'(LANES);

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  x_arr [TAPS];
    logic [DATA_W-1:0]  k_arr [TAPS];
    logic [TAP_W-1:0]   tap;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_seed;
    logic [ACC_W-1:0]   lane_p [LANES];
    logic [ACC_W-1:0]   lane_sum;
    logic               accept;
    logic               last;

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && ((tap + LANES_V) >= TAPS_V);
    assign busy   = (state == RUN);

`ifdef CONV_BIAS_EN
    assign acc_seed = bias;
`else
    assign acc_seed = '0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- operand capture ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < TAPS; t++) begin
                x_arr[t] <= '0;
                k_arr[t] <= '0;
            end
        end else if (accept) begin
            for (int t = 0; t < TAPS; t++) begin
                x_arr[t] <= `CONV_TAP(x_flat, t, DATA_W);
                k_arr[t] <= `CONV_TAP(k_flat, t, DATA_W);
            end
        end
    end

    // ---------------- lanes ----------------
    // Lanes past the last tap are fed zero operands so they add nothing.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [TAP_W-1:0]  idx;
        logic              valid;
        logic [SEL_W-1:0]  x_sel;
        logic [SEL_W-1:0]  k_sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;

        assign idx   = tap + TAP_W'(l);
        assign valid = (idx < TAPS_V);
        assign x_sel = valid ? idx[SEL_W-1:0] : '0;

        if (MODE != 0) begin : g_corr
            assign k_sel = x_sel;
        end else begin : g_conv
            // Flipping both axes of a row-major KxK index is t -> K*K-1-t.
            logic [TAP_W-1:0] flip;
            assign flip  = TAPS_V - TAP_W'(1) - idx;
            assign k_sel = valid ? flip[SEL_W-1:0] : '0;
        end

        assign a = valid ? x_arr[x_sel] : '0;
        assign b = valid ? k_arr[k_sel] : '0;

        conv_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED)
        ) u_lane (
            .a (a),
            .b (b),
            .p (lane_p[l])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + lane_p[l];
        end
    end

    // ---------------- accumulator / result ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            tap    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                acc <= acc_seed;
                tap <= '0;
            end else if (state == RUN) begin
                if (last) begin
                    result <= acc + lane_sum;
                    done   <= 1'b1;
                    acc    <= '0;
                    tap    <= '0;
                end else begin
                    acc <= acc + lane_sum;
                    tap <= tap + LANES_V;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_kxk_mac_engine.sv
// ---------------------------------------------------------------------------
// tb_conv_kxk_mac_engine
// Directed bench for conv_kxk_mac_engine. Four instances share clock, reset,
// start and operands: default (K=3, LANES=1, unsigned, convolution), a
// correlation instance, a signed instance and a LANES=4 instance.
// Optional feature macro: CONV_BIAS_EN.
// ---------------------------------------------------------------------------
module tb_conv_kxk_mac_engine;

    localparam int DW    = 8;
    localparam int KK    = 3;
    localparam int TAPS  = KK * KK;
    localparam int AW    = 20;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [TAPS*DW-1:0] x_flat;
    logic [TAPS*DW-1:0] k_flat;
`ifdef CONV_BIAS_EN
    logic [AW-1:0]     bias;
`endif

    logic d0_busy, d0_done, dc_busy, dc_done, ds_busy, ds_done, d4_busy, d4_done;
    logic [AW-1:0] d0_result, dc_result, ds_result, d4_result;

    int total;
    int bad;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    conv_kxk_mac_engine #(.DATA_W(DW), .K(KK), .LANES(1), .SIGNED(0), .MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .x_flat(x_flat), .k_flat(k_flat),
`ifdef CONV_BIAS_EN
        .bias(bias),
`endif
        .busy(d0_busy), .done(d0_done), .result(d0_result));

    conv_kxk_mac_engine #(.DATA_W(DW), .K(KK), .LANES(1), .SIGNED(0), .MODE(1)) dut_corr (
        .clk(clk), .reset_n(reset_n), .start(start), .x_flat(x_flat), .k_flat(k_flat),
`ifdef CONV_BIAS_EN
        .bias(bias),
`endif
        .busy(dc_busy), .done(dc_done), .result(dc_result));

    conv_kxk_mac_engine #(.DATA_W(DW), .K(KK), .LANES(1), .SIGNED(1), .MODE(0)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start), .x_flat(x_flat), .k_flat(k_flat),
`ifdef CONV_BIAS_EN
        .bias(bias),
`endif
        .busy(ds_busy), .done(ds_done), .result(ds_result));

    conv_kxk_mac_engine #(.DATA_W(DW), .K(KK), .LANES(4), .SIGNED(0), .MODE(0)) dut_l4 (
        .clk(clk), .reset_n(reset_n), .start(start), .x_flat(x_flat), .k_flat(k_flat),
`ifdef CONV_BIAS_EN
        .bias(bias),
`endif
        .busy(d4_busy), .done(d4_done), .result(d4_result));

    // ---------------- driver helpers ----------------
    function automatic logic [TAPS*DW-1:0] fill(input logic [DW-1:0] v);
        return {TAPS{v}};
    endfunction

    // One-shot operation: pulse start, then follow dut0 to its done pulse.
    // lat counts edges after the accept edge; busy_cnt counts sampled busy
    // cycles starting at the accept edge.
    task automatic run_op(output int lat, output int busy_cnt, output int lat4,
                          output int pulses4, output bit to);
        bit seen;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        lat4     = 0;
        pulses4  = 0;
        busy_cnt = d0_busy ? 1 : 0;
        seen     = 1'b0;
        to       = 1'b0;
        while (!seen && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (d4_done) begin
                pulses4++;
                if (lat4 == 0) lat4 = lat;
            end
            if (d0_busy) busy_cnt++;
            if (d0_done) seen = 1'b1;
        end
        if (!seen) to = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        x_flat  = '0;
        k_flat  = '0;
`ifdef CONV_BIAS_EN
        bias    = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        total++; if (d0_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", d0_busy); end
        total++; if (d0_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", d0_done); end
        total++; if (d0_result !== 20'd0) begin bad++; $display("FAIL reset_result got=%0d want=0", d0_result); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ones();
        int lat, bc, lat4, p4;
        bit to;
        x_flat = fill(8'd1);
        k_flat = fill(8'd1);
        run_op(lat, bc, lat4, p4, to);
        total++; if (to) begin bad++; $display("FAIL ones_timeout got=no_done want=done"); end
        total++; if (lat !== 9) begin bad++; $display("FAIL ones_latency got=%0d want=9", lat); end
        total++; if (bc !== 9) begin bad++; $display("FAIL ones_busy_cycles got=%0d want=9", bc); end
        total++; if (d0_result !== 20'd9) begin bad++; $display("FAIL ones_result got=%0d want=9", d0_result); end
        total++; if (lat4 !== 3) begin bad++; $display("FAIL ones_l4_latency got=%0d want=3", lat4); end
        total++; if (d4_result !== 20'd9) begin bad++; $display("FAIL ones_l4_result got=%0d want=9", d4_result); end
        @(posedge clk);
        #1;
        total++; if (d0_done !== 1'b0) begin bad++; $display("FAIL ones_done_width got=%b want=0", d0_done); end
    endtask

    task automatic test_flip();
        int lat, bc, lat4, p4;
        bit to;
        logic [TAPS*DW-1:0] xv;
        logic [TAPS*DW-1:0] kv;
        xv = '0; kv = '0;
        xv[0 +: DW] = 8'd5;          // x[0][0]
        kv[8*DW +: DW] = 8'd7;       // k[2][2]
        x_flat = xv;
        k_flat = kv;
        run_op(lat, bc, lat4, p4, to);
        total++; if (to) begin bad++; $display("FAIL flip_timeout got=no_done want=done"); end
        total++; if (d0_result !== 20'd35) begin bad++; $display("FAIL flip_conv got=%0d want=35", d0_result); end
        total++; if (dc_result !== 20'd0) begin bad++; $display("FAIL flip_corr got=%0d want=0", dc_result); end
        // kernel tap at k[0][0] instead: only correlation pairs it with x[0][0]
        kv = '0;
        kv[0 +: DW] = 8'd7;
        k_flat = kv;
        run_op(lat, bc, lat4, p4, to);
        total++; if (d0_result !== 20'd0) begin bad++; $display("FAIL flip_conv_same got=%0d want=0", d0_result); end
        total++; if (dc_result !== 20'd35) begin bad++; $display("FAIL flip_corr_same got=%0d want=35", dc_result); end
    endtask

    task automatic test_signed();
        int lat, bc, lat4, p4;
        bit to;
        x_flat = fill(8'h80);
        k_flat = fill(8'h80);
        run_op(lat, bc, lat4, p4, to);
        total++; if (to) begin bad++; $display("FAIL signed_timeout got=no_done want=done"); end
        total++; if (ds_result !== 20'd147456) begin bad++; $display("FAIL signed_neg_neg got=%0d want=147456", ds_result); end
        k_flat = fill(8'h7F);
        run_op(lat, bc, lat4, p4, to);
        // -146304 in 20-bit two's complement is 902272
        total++; if (ds_result !== 20'd902272) begin bad++; $display("FAIL signed_neg_pos got=%0d want=902272", ds_result); end
        // same bits read unsigned: 128*127*9
        total++; if (d0_result !== 20'd146304) begin bad++; $display("FAIL signed_unsigned_view got=%0d want=146304", d0_result); end
    endtask

    task automatic test_unsigned_max();
        int lat, bc, lat4, p4;
        bit to;
        x_flat = fill(8'hFF);
        k_flat = fill(8'hFF);
        run_op(lat, bc, lat4, p4, to);
        total++; if (to) begin bad++; $display("FAIL umax_timeout got=no_done want=done"); end
        total++; if (d0_result !== 20'd585225) begin bad++; $display("FAIL umax_result got=%0d want=585225", d0_result); end
        total++; if (d4_result !== 20'd585225) begin bad++; $display("FAIL umax_l4_result got=%0d want=585225", d4_result); end
        total++; if (lat4 !== 3) begin bad++; $display("FAIL umax_l4_latency got=%0d want=3", lat4); end
        total++; if (p4 !== 1) begin bad++; $display("FAIL umax_l4_done_pulses got=%0d want=1", p4); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        @(negedge clk);
        x_flat = fill(8'd1);
        k_flat = fill(8'd1);
        start  = 1'b1;
        @(posedge clk);              // accept with all ones
        #1;
        x_flat = fill(8'd2);         // next operation's operands
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(posedge clk); #1; cyc++;
            if (d0_done) seen = 1'b1;
        end
        total++; if (!seen || cyc != 9) begin bad++; $display("FAIL b2b_first_latency got=%0d want=9", cyc); end
        total++; if (d0_result !== 20'd9) begin bad++; $display("FAIL b2b_first_result got=%0d want=9", d0_result); end
        @(posedge clk);              // start held through the done cycle: accepted here
        #1;
        x_flat = fill(8'd3);
        total++; if (d0_busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept_busy got=%b want=1", d0_busy); end
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(posedge clk); #1; cyc++;
            if (d0_done) seen = 1'b1;
        end
        total++; if (!seen || cyc != 10) begin bad++; $display("FAIL b2b_done_interval got=%0d want=10", cyc); end
        total++; if (d0_result !== 20'd18) begin bad++; $display("FAIL b2b_second_result got=%0d want=18", d0_result); end
        start = 1'b0;                // low in the done cycle: no new operation
        @(posedge clk); #1;
        total++; if (d0_busy !== 1'b0) begin bad++; $display("FAIL b2b_stop_busy got=%b want=0", d0_busy); end
        total++; if (d0_result !== 20'd18) begin bad++; $display("FAIL b2b_result_held got=%0d want=18", d0_result); end

        // start pulsed mid-RUN with different operands must be ignored
        @(negedge clk);
        x_flat = fill(8'd1);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        x_flat = fill(8'd3);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 4; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(posedge clk); #1; cyc++;
            if (d0_done) seen = 1'b1;
        end
        total++; if (!seen || cyc != 9) begin bad++; $display("FAIL midrun_latency got=%0d want=9", cyc); end
        total++; if (d0_result !== 20'd9) begin bad++; $display("FAIL midrun_result got=%0d want=9", d0_result); end
        @(posedge clk); #1;
        total++; if (d0_busy !== 1'b0) begin bad++; $display("FAIL midrun_no_restart got=%b want=0", d0_busy); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, lat4, p4, pulses;
        bit to;
        logic [AW-1:0] exp_res;
        @(negedge clk);
        x_flat = fill(8'd1);
        k_flat = fill(8'd1);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (d0_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", d0_busy); end
        total++; if (d0_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", d0_done); end
        total++; if (d0_result !== 20'd0) begin bad++; $display("FAIL abort_result got=%0d want=0", d0_result); end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (d0_done) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
`ifdef CONV_BIAS_EN
        bias    = 20'd100;
        exp_res = 20'd109;
`else
        exp_res = 20'd9;
`endif
        run_op(lat, bc, lat4, p4, to);
        total++; if (to) begin bad++; $display("FAIL restart_timeout got=no_done want=done"); end
        total++; if (d0_result !== exp_res) begin bad++; $display("FAIL restart_result got=%0d want=%0d", d0_result, exp_res); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ones();
        test_flip();
        test_signed();
        test_unsigned_max();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
